// File: rtl/mc_main_ctrl_if.sv
// rtl/mc_main_ctrl_if.sv - control/datapath bundle between mc_main_ctrl and the multi-cycle RV32 datapath
// Optional port illegal exists only when RV_ILLEGAL_TRAP_EN is defined.
interface mc_main_ctrl_if;
  logic [6:0] op;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic       instr_done;
  logic [3:0] state_o;
`ifdef RV_ILLEGAL_TRAP_EN
  logic       illegal;

  modport master (
    input  op, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUOp, ImmSrc, RegWrite, instr_done, state_o, illegal
  );
  modport slave (
    output op, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUOp, ImmSrc, RegWrite, instr_done, state_o, illegal
  );
`else
  modport master (
    input  op, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUOp, ImmSrc, RegWrite, instr_done, state_o
  );
  modport slave (
    output op, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUOp, ImmSrc, RegWrite, instr_done, state_o
  );
`endif
endinterface

// File: rtl/mc_main_ctrl.sv
// rtl/mc_main_ctrl.sv - main control FSM of the multi-cycle RV32 core (lw, sw, R, I, beq, jal)
// Optional: RV_ILLEGAL_TRAP_EN traps unknown opcodes in a sticky TRAP state instead of retiring them as NOPs.
module mc_main_ctrl #(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  mc_main_ctrl_if.master bus
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       branch;
    logic       pc_update;
    logic       done;
`ifdef RV_ILLEGAL_TRAP_EN
    logic       illegal;
`endif
  } moore_t;

  // State-only outputs; input-dependent terms are merged in after the register.
  function automatic moore_t moore_of(state_t s);
    moore_t m;
    m = '0;
    case (s)
      S_FETCH:    begin m.alu_src_b = 2'b10; m.result_src = 2'b10; end
      S_DECODE:   begin m.alu_src_a = 2'b01; m.alu_src_b = 2'b01; end
      S_MEMADR:   begin m.alu_src_a = 2'b10; m.alu_src_b = 2'b01; end
      S_MEMREAD:  m.adr_src = 1'b1;
      S_MEMWB:    begin m.result_src = 2'b01; m.reg_write = 1'b1; m.done = 1'b1; end
      S_MEMWRITE: begin m.adr_src = 1'b1; m.mem_write = 1'b1; end
      S_EXECR:    begin m.alu_src_a = 2'b10; m.alu_op = 2'b10; end
      S_EXECI:    begin m.alu_src_a = 2'b10; m.alu_src_b = 2'b01; m.alu_op = 2'b10; end
      S_ALUWB:    begin m.reg_write = 1'b1; m.done = 1'b1; end
      S_BEQ:      begin m.alu_src_a = 2'b10; m.alu_op = 2'b01; m.branch = 1'b1; m.done = 1'b1; end
      S_JAL:      begin m.alu_src_a = 2'b01; m.alu_src_b = 2'b10; m.pc_update = 1'b1; end
`ifdef RV_ILLEGAL_TRAP_EN
      S_TRAP:     m.illegal = 1'b1;
`endif
      default:    m = '0;
    endcase
    return m;
  endfunction

  state_t state_q, state_d;
  moore_t mo_q;
  logic   mem_rdy;
  logic   unknown_nop;

  assign mem_rdy = USE_MEM_READY ? bus.mem_ready : 1'b1;

  always_comb begin
    state_d     = state_q;
    unknown_nop = 1'b0;
    case (state_q)
      S_FETCH:    if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
`ifdef RV_ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            // PC was already advanced in FETCH, so the unknown op retires as a NOP here.
            state_d     = S_FETCH;
            unknown_nop = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR:   state_d = (bus.op == OP_SW) ? S_MEMWRITE :
                            (bus.op == OP_LW) ? S_MEMREAD  : S_FETCH;
      S_MEMREAD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_rdy) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
`ifdef RV_ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      mo_q    <= moore_of(S_FETCH);
    end else begin
      state_q <= state_d;
      mo_q    <= moore_of(state_d);
    end
  end

  logic in_fetch, in_memwrite, fetch_go;
  assign in_fetch    = (state_q == S_FETCH);
  assign in_memwrite = (state_q == S_MEMWRITE);
  assign fetch_go    = in_fetch & mem_rdy;

  assign bus.PCWrite    = ~reset & ((mo_q.branch & bus.Zero) | mo_q.pc_update | fetch_go);
  assign bus.IRWrite    = ~reset & fetch_go;
  assign bus.AdrSrc     = ~reset & mo_q.adr_src;
  assign bus.MemWrite   = ~reset & mo_q.mem_write;
  assign bus.ResultSrc  = reset ? 2'b00 : mo_q.result_src;
  assign bus.ALUSrcA    = reset ? 2'b00 : mo_q.alu_src_a;
  assign bus.ALUSrcB    = reset ? 2'b00 : mo_q.alu_src_b;
  assign bus.ALUOp      = reset ? 2'b00 : mo_q.alu_op;
  assign bus.RegWrite   = ~reset & mo_q.reg_write;
  assign bus.instr_done = ~reset & (mo_q.done | (in_memwrite & mem_rdy) | unknown_nop);
  assign bus.state_o    = state_q;
`ifdef RV_ILLEGAL_TRAP_EN
  assign bus.illegal    = ~reset & mo_q.illegal;
`endif

  always_comb begin
    case (bus.op)
      OP_SW:   bus.ImmSrc = 2'b01;
      OP_BEQ:  bus.ImmSrc = 2'b10;
      OP_JAL:  bus.ImmSrc = 2'b11;
      default: bus.ImmSrc = 2'b00;
    endcase
  end

endmodule
